debounce_multi: RTL and testbench



---
 rtl/debounce_pkg.sv | 23 ++
 rtl/debounce_ch.sv | 100 ++++++++++
 rtl/debounce_multi.sv | 44 ++++
 tb/tb_debounce_multi.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the multi-channel button debouncer: default and board parameter values
// plus counter-width helpers. Optional long-press support is enabled by DEBOUNCE_LONGPRESS_EN.
package debounce_pkg;

   localparam int DEF_N_CH          = 4;
   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 16;
   localparam int DEF_LONG_CYCLES   = 1000;

   // Board build: 50 MHz clk, 10 ms debounce window, 1 s long press.
   localparam int BOARD_CLK_HZ        = 50_000_000;
   localparam int BOARD_STABLE_CYCLES = BOARD_CLK_HZ / 100;
   localparam int BOARD_LONG_CYCLES   = BOARD_CLK_HZ;

   localparam int CNT_W  = $clog2(DEF_STABLE_CYCLES + 1);
   localparam int HOLD_W = $clog2(DEF_LONG_CYCLES + 1);

   // Width of a counter that must hold the values 0..n.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: synchroniser, stability counter, level and edge-pulse registers.
// With DEBOUNCE_LONGPRESS_EN defined, also a hold counter driving a one-shot long_press pulse.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic level,
   output logic rise,
`ifdef DEBOUNCE_LONGPRESS_EN
   output logic fall,
   output logic long_press
`else
   output logic fall
`endif
);

   localparam int CNT_BITS = cnt_width(STABLE_CYCLES);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [CNT_BITS-1:0]    r_cnt;
   logic                   r_level;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_sync;
   logic                   w_differ;
   logic                   w_flip;

   assign w_sync   = r_sync[SYNC_STAGES-1];
   assign w_differ = (w_sync != r_level);
   assign w_flip   = w_differ && (r_cnt == CNT_BITS'(STABLE_CYCLES - 1));

   // NOTE: every register here, sync chain included, uses <= and is cleared by rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync  <= '0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
         r_rise <= w_flip & w_sync;
         r_fall <= w_flip & ~w_sync;
         if (!w_differ || w_flip)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + CNT_BITS'(1);
         if (w_flip)
            r_level <= w_sync;
      end
   end

   assign level = r_level;
   assign rise  = r_rise;
   assign fall  = r_fall;

`ifdef DEBOUNCE_LONGPRESS_EN
   localparam int HOLD_BITS = cnt_width(LONG_CYCLES);

   logic [HOLD_BITS-1:0] r_hold;
   logic [HOLD_BITS-1:0] w_hold_next;
   logic                 r_long;
   logic                 w_level_next;
   logic                 w_long_fire;

   assign w_level_next = w_flip ? w_sync : r_level;

   always_comb begin
      w_hold_next = r_hold;
      if (!r_level || w_flip)
         w_hold_next = '0;
      else if (r_hold != HOLD_BITS'(LONG_CYCLES))
         w_hold_next = r_hold + HOLD_BITS'(1);
   end

   // Fire only on arrival at LONG_CYCLES-1, so saturation cannot retrigger.
   assign w_long_fire = w_level_next
                     && (w_hold_next == HOLD_BITS'(LONG_CYCLES - 1))
                     && ((w_hold_next != r_hold) || w_flip);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold <= '0;
         r_long <= 1'b0;
      end else begin
         r_hold <= w_hold_next;
         r_long <= w_long_fire;
      end
   end

   assign long_press = r_long;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N_CH independent button debouncers sharing clk and a synchronous active-high rst.
// Defining DEBOUNCE_LONGPRESS_EN adds the per-channel long_press output.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int N_CH          = DEF_N_CH,
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int LONG_CYCLES   = DEF_LONG_CYCLES
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] btn,
   output logic [N_CH-1:0] level,
   output logic [N_CH-1:0] rise,
`ifdef DEBOUNCE_LONGPRESS_EN
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] long_press
`else
   output logic [N_CH-1:0] fall
`endif
);

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      debounce_ch #(
         .SYNC_STAGES  (SYNC_STAGES),
         .STABLE_CYCLES(STABLE_CYCLES),
         .LONG_CYCLES  (LONG_CYCLES)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .btn       (btn[g]),
         .level     (level[g]),
         .rise      (rise[g]),
`ifdef DEBOUNCE_LONGPRESS_EN
         .fall      (fall[g]),
         .long_press(long_press[g])
`else
         .fall      (fall[g])
`endif
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (2 channels, 2 sync stages, 4-cycle filter).
// Long-press checks are compiled in when DEBOUNCE_LONGPRESS_EN is defined.
module tb_debounce_multi;

   localparam int N_CH   = 2;
   localparam int SYNC   = 2;
   localparam int STABLE = 4;
   localparam int LONG   = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N_CH-1:0] btn = '0;
   logic [N_CH-1:0] level;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] fall;
`ifdef DEBOUNCE_LONGPRESS_EN
   logic [N_CH-1:0] long_press;
`endif

   typedef struct packed {
      logic       rst;
      logic [1:0] btn;
      logic [1:0] level;
      logic [1:0] rise;
      logic [1:0] fall;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   debounce_multi #(
      .N_CH         (N_CH),
      .SYNC_STAGES  (SYNC),
      .STABLE_CYCLES(STABLE),
      .LONG_CYCLES  (LONG)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .btn       (btn),
      .level     (level),
      .rise      (rise),
`ifdef DEBOUNCE_LONGPRESS_EN
      .fall      (fall),
      .long_press(long_press)
`else
      .fall      (fall)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [1:0] b, input logic [1:0] l,
                      input logic [1:0] ri, input logic [1:0] fa, input int n);
      vec_t v;
      v.rst = r; v.btn = b; v.level = l; v.rise = ri; v.fall = fa;
      for (int i = 0; i < n; i++) tbl.push_back(v);
   endtask

   // Drive one vector, let one rising edge happen, then compare against the scoreboard.
   task automatic apply(input vec_t v, input int idx);
      vec_t e;
      @(negedge clk);
      rst = v.rst;
      btn = v.btn;
      sb.push_back(v);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("vec%0d lvl/rise/fall", idx), {26'd0, level, rise, fall},
            {26'd0, e.level, e.rise, e.fall});
   endtask

   task automatic wait_level0(input string name);
      for (int k = 0; k < 20 && level[0] !== 1'b0; k++) begin
         @(posedge clk);
         #1;
      end
      check(name, {31'd0, level[0]}, 32'd0);
   endtask

   initial begin
      // Reset with btn held high: outputs stay 0, then full latency once released.
      add(1, 2'b11, 2'b00, 2'b00, 2'b00, 3);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b11, 2'b11, 2'b11, 2'b00, 1);
      add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2);
      // Release both channels.
      add(0, 2'b00, 2'b11, 2'b00, 2'b00, 5);
      add(0, 2'b00, 2'b00, 2'b00, 2'b11, 1);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // Bounce on ch0: 3 high, 1 low, 3 high, 1 low, then steady high.
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b01, 2'b01, 2'b00, 2'b00, 2);
      // Release ch0 only.
      add(0, 2'b00, 2'b01, 2'b00, 2'b00, 5);
      add(0, 2'b00, 2'b00, 2'b00, 2'b01, 1);
      add(0, 2'b00, 2'b00, 2'b00, 2'b00, 2);
      // Independence: ch1 rises two cycles after ch0.
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 2);
      add(0, 2'b11, 2'b00, 2'b00, 2'b00, 3);
      add(0, 2'b11, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b11, 2'b01, 2'b00, 2'b00, 1);
      add(0, 2'b11, 2'b11, 2'b10, 2'b00, 1);
      add(0, 2'b11, 2'b11, 2'b00, 2'b00, 2);
      // Reset mid-count: partial count on ch0 is discarded.
      add(1, 2'b00, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 3);
      add(1, 2'b01, 2'b00, 2'b00, 2'b00, 1);
      add(0, 2'b01, 2'b00, 2'b00, 2'b00, 5);
      add(0, 2'b01, 2'b01, 2'b01, 2'b00, 1);
      add(0, 2'b01, 2'b01, 2'b00, 2'b00, 1);

      foreach (tbl[i]) apply(tbl[i], i);
      check("scoreboard drained", sb.size(), 32'd0);

`ifdef DEBOUNCE_LONGPRESS_EN
      begin
         int rise_at;
         int lp_at;
         int lp_cnt;
         int rise_cnt;
         @(negedge clk);
         btn = 2'b00;
         wait_level0("lp release 1");
         // 30-cycle hold: one long_press, 9 edges after rise.
         @(negedge clk);
         btn = 2'b01;
         rise_at = -1; lp_at = -1; lp_cnt = 0;
         for (int c = 1; c <= 30; c++) begin
            @(posedge clk);
            #1;
            if (rise[0]) rise_at = c;
            if (long_press[0]) begin
               lp_cnt++;
               lp_at = c;
            end
            if (long_press[1]) lp_cnt += 100;
         end
         check("long rise edge", rise_at, 32'd6);
         check("long pulse count", lp_cnt, 32'd1);
         check("long pulse edge", lp_at, 32'd15);
         @(negedge clk);
         btn = 2'b00;
         wait_level0("lp release 2");
         // 5-cycle hold: level goes high briefly, no long_press.
         lp_cnt = 0; rise_cnt = 0;
         for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            btn = (c <= 5) ? 2'b01 : 2'b00;
            @(posedge clk);
            #1;
            if (rise[0]) rise_cnt++;
            if (long_press != 2'b00) lp_cnt++;
         end
         check("short rise count", rise_cnt, 32'd1);
         check("short no long_press", lp_cnt, 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
